trace_nexus_buffer: RTL and testbench

- Parametrised successor to the two-lane retire-trace bundle nexus. It carries N retire-trace lanes (valid, iaddr, insn, priv, exception, interrupt, cause, tval, wdata) from core to trace sinks.
- Adds a per-lane elastic FIFO, so slow sinks can apply backpressure via ready/valid. The core side has no backpressure: when a lane's FIFO is full, records are dropped and accounted for.
- Sits between the core trace port and the trace encoder/ingress.

---
 rtl/trace_nexus_pkg.sv | 34 +++
 rtl/trace_lane_fifo.sv | 72 +++++++
 rtl/trace_nexus_buffer.sv | 44 ++++
 tb/tb_trace_nexus_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_nexus_pkg.sv
// Shared widths, record layout and pack/unpack offsets for the retire-trace nexus.
// The struct and offsets describe the default XLEN/IADDR_W record.
package trace_nexus_pkg;

    localparam int TRACE_INSN_W = 32;
    localparam int TRACE_PRIV_W = 3;
    localparam int DEF_XLEN     = 64;
    localparam int DEF_IADDR_W  = 40;

    function automatic int rec_w(input int iaddr_w, input int xlen);
        return 1 + 1 + TRACE_PRIV_W + TRACE_INSN_W + 2 * iaddr_w + 2 * xlen;
    endfunction

    localparam int OFS_WDATA     = 0;
    localparam int OFS_TVAL      = OFS_WDATA + DEF_XLEN;
    localparam int OFS_CAUSE     = OFS_TVAL + DEF_IADDR_W;
    localparam int OFS_INTERRUPT = OFS_CAUSE + DEF_XLEN;
    localparam int OFS_EXCEPTION = OFS_INTERRUPT + 1;
    localparam int OFS_PRIV      = OFS_EXCEPTION + 1;
    localparam int OFS_INSN      = OFS_PRIV + TRACE_PRIV_W;
    localparam int OFS_IADDR     = OFS_INSN + TRACE_INSN_W;

    typedef struct packed {
        logic [DEF_IADDR_W-1:0]  iaddr;
        logic [TRACE_INSN_W-1:0] insn;
        logic [TRACE_PRIV_W-1:0] priv;
        logic                    exception;
        logic                    interrupt;
        logic [DEF_XLEN-1:0]     cause;
        logic [DEF_IADDR_W-1:0]  tval;
        logic [DEF_XLEN-1:0]     wdata;
    } trace_rec_t;

endpackage

// File: rtl/trace_lane_fifo.sv
// One retire-trace lane: elastic FIFO toward the sink, plus drop accounting
// for records that arrive while the FIFO is full and not draining.
module trace_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int REC_W = 245,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [REC_W-1:0] in_rec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_rec,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    input  logic             clear_stats
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the slot the incoming record needs.
    assign push  = in_valid && (!full || pop);
    assign drop  = in_valid && full && !pop;

    assign out_valid = !empty;
    assign out_rec   = empty ? '0 : mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[PW-2:0]] <= in_rec;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (clear_stats) begin
                drop_count <= drop ? CNT_W'(1) : '0;
                overflow   <= drop;
            end else if (drop) begin
                if (drop_count != {CNT_W{1'b1}}) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_nexus_buffer.sv
// N-lane retire-trace nexus: each lane gets its own elastic FIFO so a slow
// trace sink can backpressure without stalling the core.
module trace_nexus_buffer
    import trace_nexus_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4,
    parameter int XLEN      = 64,
    parameter int IADDR_W   = 40,
    parameter int CNT_W     = 16,
    localparam int REC_W    = rec_w(IADDR_W, XLEN)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_LANES-1:0]       in_valid,
    input  logic [NUM_LANES*REC_W-1:0] in_rec,
    output logic [NUM_LANES-1:0]       out_valid,
    input  logic [NUM_LANES-1:0]       out_ready,
    output logic [NUM_LANES*REC_W-1:0] out_rec,
    output logic [NUM_LANES*CNT_W-1:0] drop_count,
    output logic [NUM_LANES-1:0]       overflow,
    input  logic                       clear_stats
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        trace_lane_fifo #(
            .DEPTH (DEPTH),
            .REC_W (REC_W),
            .CNT_W (CNT_W)
        ) u_lane (
            .clock       (clock),
            .reset       (reset),
            .in_valid    (in_valid[g]),
            .in_rec      (in_rec[g*REC_W +: REC_W]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_rec     (out_rec[g*REC_W +: REC_W]),
            .drop_count  (drop_count[g*CNT_W +: CNT_W]),
            .overflow    (overflow[g]),
            .clear_stats (clear_stats)
        );
    end

endmodule

// File: tb/tb_trace_nexus_buffer.sv
// Scoreboard bench for trace_nexus_buffer: per-lane queue model of accepted
// records and drop counters, directed scenarios followed by random traffic.
module tb_trace_nexus_buffer;
    import trace_nexus_pkg::*;

    localparam int NL  = 2;
    localparam int DEP = 4;
    localparam int XL  = 64;
    localparam int IW  = 40;
    localparam int CW  = 4;
    localparam int RW  = rec_w(IW, XL);
    localparam int SAT = (1 << CW) - 1;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NL-1:0]       in_valid;
    logic [NL*RW-1:0]    in_rec;
    logic [NL-1:0]       out_valid;
    logic [NL-1:0]       out_ready;
    logic [NL*RW-1:0]    out_rec;
    logic [NL*CW-1:0]    drop_count;
    logic [NL-1:0]       overflow;
    logic                clear_stats;

    always #5 clock = ~clock;

    trace_nexus_buffer #(
        .NUM_LANES (NL),
        .DEPTH     (DEP),
        .XLEN      (XL),
        .IADDR_W   (IW),
        .CNT_W     (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_rec      (in_rec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rec     (out_rec),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .clear_stats (clear_stats)
    );

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] exp_q [NL][$];
    int            exp_cnt [NL];
    bit            exp_ovf [NL];

    task automatic check(input string name, input int lane, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane %0d at %0t: got %h expected %h", name, lane, $time, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_rec(input logic [IW-1:0] ia, input logic [31:0] ins);
        trace_rec_t r;
        r.iaddr     = ia;
        r.insn      = ins;
        r.priv      = 3'($urandom);
        r.exception = 1'($urandom);
        r.interrupt = 1'($urandom);
        r.cause     = {$urandom, $urandom};
        r.tval      = {8'($urandom), $urandom};
        r.wdata     = {$urandom, $urandom};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            exp_q[i].delete();
            exp_cnt[i] = 0;
            exp_ovf[i] = 1'b0;
        end
    endtask

    // Reference: at each edge the head leaves if the sink is ready, then the
    // arriving record joins if there is room, otherwise it is counted as dropped.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                bit dropped;
                dropped = 1'b0;
                check("out_valid", i, 256'(out_valid[i]), 256'(exp_q[i].size() > 0));
                if (exp_q[i].size() > 0 && out_ready[i]) begin
                    check("head_rec", i, 256'(out_rec[i*RW +: RW]), 256'(exp_q[i][0]));
                    void'(exp_q[i].pop_front());
                end
                if (in_valid[i]) begin
                    if (exp_q[i].size() < DEP) exp_q[i].push_back(in_rec[i*RW +: RW]);
                    else dropped = 1'b1;
                end
                if (clear_stats) begin
                    exp_cnt[i] = dropped ? 1 : 0;
                    exp_ovf[i] = dropped;
                end else if (dropped) begin
                    if (exp_cnt[i] < SAT) exp_cnt[i]++;
                    exp_ovf[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                check("drop_count", i, 256'(drop_count[i*CW +: CW]), 256'(exp_cnt[i]));
                check("overflow", i, 256'(overflow[i]), 256'(exp_ovf[i]));
                if (!out_valid[i]) check("idle_rec_zero", i, 256'(out_rec[i*RW +: RW]), 256'(0));
            end
        end
    end

    task automatic idle_inputs();
        in_valid    = '0;
        in_rec      = '0;
        out_ready   = '0;
        clear_stats = 1'b0;
    endtask

    task automatic push0(input logic [IW-1:0] ia);
        in_valid[0]     = 1'b1;
        in_rec[0 +: RW] = mk_rec(ia, $urandom);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check("reset_out_valid", 0, 256'(out_valid), 256'(0));
        check("reset_out_rec", 0, 256'(out_rec), 256'(0));
        check("reset_drop_count", 0, 256'(drop_count), 256'(0));
        check("reset_overflow", 0, 256'(overflow), 256'(0));

        // Single record on lane 0, visible one edge later, retired the next.
        out_ready       = '1;
        in_valid[0]     = 1'b1;
        in_rec[0 +: RW] = mk_rec(40'h80000000, 32'h00000013);
        @(negedge clock);
        in_valid = '0;
        check("single_valid", 0, 256'(out_valid), 256'(2'b01));
        check("single_iaddr", 0, 256'(out_rec[OFS_IADDR +: IW]), 256'(40'h80000000));
        check("single_insn", 0, 256'(out_rec[OFS_INSN +: 32]), 256'(32'h00000013));
        @(negedge clock);
        check("single_retired", 0, 256'(out_valid), 256'(0));

        // Fill and drop: six pushes into a stalled lane.
        out_ready = '0;
        for (int k = 0; k < 6; k++) begin
            push0(IW'(k));
            @(negedge clock);
        end
        in_valid = '0;
        check("fill_drop_count", 0, 256'(drop_count[0 +: CW]), 256'(2));
        check("fill_overflow", 0, 256'(overflow[0]), 256'(1));
        check("fill_head", 0, 256'(out_rec[OFS_IADDR +: IW]), 256'(0));
        out_ready[0] = 1'b1;
        repeat (4) @(negedge clock);
        check("fill_drained", 0, 256'(out_valid[0]), 256'(0));

        // Full lane with simultaneous push and pop keeps occupancy, no drop.
        out_ready = '0;
        for (int k = 0; k < 4; k++) begin
            push0(IW'(16 + k));
            @(negedge clock);
        end
        out_ready[0] = 1'b1;
        push0(IW'(20));
        @(negedge clock);
        in_valid  = '0;
        out_ready = '0;
        check("pushpop_no_drop", 0, 256'(drop_count[0 +: CW]), 256'(2));
        check("pushpop_head", 0, 256'(out_rec[OFS_IADDR +: IW]), 256'(17));

        // Saturation with 20 further drops, then clear with and without a drop.
        for (int k = 0; k < 20; k++) begin
            push0(IW'(32 + k));
            @(negedge clock);
        end
        in_valid = '0;
        check("sat_count", 0, 256'(drop_count[0 +: CW]), 256'(SAT));
        clear_stats = 1'b1;
        push0(IW'(99));
        @(negedge clock);
        in_valid = '0;
        check("clear_drop_count", 0, 256'(drop_count[0 +: CW]), 256'(1));
        check("clear_drop_ovf", 0, 256'(overflow[0]), 256'(1));
        @(negedge clock);
        clear_stats = 1'b0;
        check("clear_count", 0, 256'(drop_count[0 +: CW]), 256'(0));
        check("clear_ovf", 0, 256'(overflow[0]), 256'(0));

        // Leave three records queued, then reset between edges.
        out_ready[0] = 1'b1;
        @(negedge clock);
        out_ready = '0;
        check("pre_reset_valid", 0, 256'(out_valid[0]), 256'(1));
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async_out_valid", 0, 256'(out_valid), 256'(0));
        check("async_out_rec", 0, 256'(out_rec), 256'(0));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_empty", 0, 256'(out_valid), 256'(0));

        // Random traffic on both lanes.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NL; i++) begin
                in_valid[i]      = ($urandom_range(0, 99) < 60);
                out_ready[i]     = ($urandom_range(0, 99) < 45);
                in_rec[i*RW +: RW] = mk_rec({8'($urandom), $urandom}, $urandom);
            end
            clear_stats = ($urandom_range(0, 99) < 3);
            @(negedge clock);
        end
        idle_inputs();
        out_ready = '1;
        repeat (DEP + 2) @(negedge clock);
        check("final_drained", 0, 256'(out_valid), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
